serial_port: RTL and testbench

- Bus responder for the serial link registers: SB ($FF01) and SC ($FF02).
- Sits on the peripheral end of the MMU's serial bus, and performs 8-bit shift transfers on the link using the internal or external clock.
- On completion it pulses the serial interrupt request, and presents each transmitted byte on a capture port for test-ROM console output.

---
 rtl/serial_port_pkg.sv | 24 ++
 rtl/bus_if.sv | 19 +
 rtl/serial_port_clock_gen.sv | 40 ++++
 rtl/serial_port.sv | 131 +++++++++++++
 tb/tb_serial_port.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_port_pkg.sv
// Serial link types and register addresses shared by serial_port and its clock generator.
// Exposes SB/SC addresses, the serial window bounds and the derived transfer state.
package serial_port_pkg;

  localparam logic [15:0] SB_addr           = 16'hFF01;
  localparam logic [15:0] SC_addr           = 16'hFF02;
  localparam logic [15:0] SERIAL_addr_start = 16'hFF01;
  localparam logic [15:0] SERIAL_addr_end   = 16'hFF02;

  typedef enum logic [1:0] {
    SERIAL_IDLE,
    SERIAL_XFER_INT,
    SERIAL_XFER_EXT
  } serial_state_t;

  function automatic serial_state_t serial_state(
    input logic start,
    input logic clk_sel
  );
    if (!start) return SERIAL_IDLE;
    return clk_sel ? SERIAL_XFER_INT : SERIAL_XFER_EXT;
  endfunction

endpackage

// File: rtl/bus_if.sv
// MMU-to-peripheral register bus: addr/wdata/read_en/write_en towards the peripheral,
// rdata back. Peripheral_side is the responder view, Mmu_side the requester view.
interface Bus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        read_en;
  logic        write_en;
  logic [7:0]  rdata;

  modport Peripheral_side (
    input  addr, wdata, read_en, write_en,
    output rdata
  );

  modport Mmu_side (
    output addr, wdata, read_en, write_en,
    input  rdata
  );
endinterface

// File: rtl/serial_port_clock_gen.sv
// serial_clock_gen: internal link clock. In: clk, reset, enable (XFER_INT), clear (SC write).
// Out: shift_strobe on the last tick of each bit, serial_clk_out low for the first half-bit.
module serial_clock_gen #(
  parameter int CLKS_PER_BIT = 512
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic shift_strobe,
  output logic serial_clk_out
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);

  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    tick_d = tick_q;
    if (clear || !enable) begin
      tick_d = '0;
    end else if (tick_q == LAST) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_d;
  end

  assign shift_strobe   = enable && !clear && (tick_q == LAST);
  // Idles high whenever the internal clock is not driving the link.
  assign serial_clk_out = !enable || (tick_q >= HALF);

endmodule

// File: rtl/serial_port.sv
// serial_port: SB/SC register responder with an 8-bit shift link on internal or external clock.
// Ports: bus (Peripheral_side), serial_in/ext_clk in; serial_out, serial_clk_out, serial_irq, tx_byte/tx_valid out.
module serial_port
  import serial_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  Bus_if.Peripheral_side       bus,
  input  logic                 serial_in,
  input  logic                 ext_clk,
  output logic                 serial_out,
  output logic                 serial_clk_out,
  output logic                 serial_irq,
  output logic [7:0]           tx_byte,
  output logic                 tx_valid
);

  logic [7:0] sb_q, sb_d;
  logic       start_q, start_d;
  logic       clk_sel_q, clk_sel_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       ext_clk_q, ext_clk_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_valid_q, tx_valid_d;
  logic       irq_q, irq_d;

  serial_state_t state;
  logic          sb_wr, sc_wr;
  logic          int_shift, shift, shift_ok;

  assign state = serial_state(start_q, clk_sel_q);
  assign sb_wr = bus.write_en && (bus.addr == SB_addr);
  assign sc_wr = bus.write_en && (bus.addr == SC_addr);

  serial_clock_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_clock_gen (
    .clk            (clk),
    .reset          (reset),
    .enable         (state == SERIAL_XFER_INT),
    .clear          (sc_wr),
    .shift_strobe   (int_shift),
    .serial_clk_out (serial_clk_out)
  );

  always_comb begin
    case (state)
      SERIAL_XFER_INT: shift = int_shift;
      SERIAL_XFER_EXT: shift = ext_clk && !ext_clk_q;
      default:         shift = 1'b0;
    endcase
  end

  // A CPU write to SB in the shift cycle replaces the shift entirely.
  assign shift_ok = shift && !sb_wr;

  always_comb begin
    sb_d       = sb_q;
    start_d    = start_q;
    clk_sel_d  = clk_sel_q;
    bit_cnt_d  = bit_cnt_q;
    ext_clk_d  = ext_clk;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    irq_d      = 1'b0;

    if (shift_ok) begin
      sb_d      = {sb_q[6:0], serial_in};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        start_d = 1'b0;
        irq_d   = 1'b1;
      end
    end

    if (sb_wr) sb_d = bus.wdata;

    // SC writes override any completion in the same cycle.
    if (sc_wr) begin
      start_d   = bus.wdata[7];
      clk_sel_d = bus.wdata[0];
      bit_cnt_d = 3'd0;
      irq_d     = 1'b0;
      if (bus.wdata[7]) begin
        tx_byte_d  = sb_q;
        tx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q       <= 8'h00;
      start_q    <= 1'b0;
      clk_sel_q  <= 1'b0;
      bit_cnt_q  <= 3'd0;
      ext_clk_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sb_q       <= sb_d;
      start_q    <= start_d;
      clk_sel_q  <= clk_sel_d;
      bit_cnt_q  <= bit_cnt_d;
      ext_clk_q  <= ext_clk_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    bus.rdata = 8'hFF;
    if (bus.read_en) begin
      case (bus.addr)
        SB_addr: bus.rdata = sb_q;
        SC_addr: bus.rdata = {start_q, 6'b111111, clk_sel_q};
        default: bus.rdata = 8'hFF;
      endcase
    end
  end

  assign serial_out = sb_q[7];
  assign serial_irq = irq_q;
  assign tx_byte    = tx_byte_q;
  assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_serial_port.sv
// Self-checking bench for serial_port with CLKS_PER_BIT=8.
// Expected link behaviour is computed from bit position and elapsed cycles.
module tb_serial_port;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       ext_clk;
  logic       serial_out;
  logic       serial_clk_out;
  logic       serial_irq;
  logic [7:0] tx_byte;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;

  Bus_if bus_i();

  serial_port #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_i),
    .serial_in      (serial_in),
    .ext_clk        (ext_clk),
    .serial_out     (serial_out),
    .serial_clk_out (serial_clk_out),
    .serial_irq     (serial_irq),
    .tx_byte        (tx_byte),
    .tx_valid       (tx_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // SB contents after s bits have been shifted in from a constant serial_in.
  function automatic logic [7:0] shifted(input logic [7:0] b,
                                         input logic sin, input int s);
    logic [7:0] fill;
    if (s >= 8) return {8{sin}};
    fill = sin ? 8'((1 << s) - 1) : 8'h00;
    return 8'(b << s) | fill;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_i.addr     = a;
    bus_i.wdata    = d;
    bus_i.write_en = 1'b1;
    @(posedge clk);
    #1;
    bus_i.write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus_i.addr    = a;
    bus_i.read_en = 1'b1;
    #1;
    d             = bus_i.rdata;
    bus_i.read_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    serial_in = 1'b0;
    ext_clk = 1'b0;
    bus_i.addr = 16'h0000;
    bus_i.wdata = 8'h00;
    bus_i.read_en = 1'b0;
    bus_i.write_en = 1'b0;
    repeat (3) cyc();
    checks++;
    if (serial_out !== 1'b0) begin
      errors++; $display("FAIL rst_sout: got %b want 0", serial_out);
    end
    checks++;
    if (serial_clk_out !== 1'b1) begin
      errors++; $display("FAIL rst_sck: got %b want 1", serial_clk_out);
    end
    checks++;
    if (serial_irq !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL rst_strobes: irq %b txv %b want 0 0", serial_irq, tx_valid);
    end
    checks++;
    if (tx_byte !== 8'h00) begin
      errors++; $display("FAIL rst_txbyte: got %h want 00", tx_byte);
    end
    reset = 1'b0;
    rd(16'hFF01, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL rst_sb: got %h want 00", d);
    end
    rd(16'hFF02, d);
    checks++;
    if (d !== 8'h7E) begin
      errors++; $display("FAIL rst_sc: got %h want 7e", d);
    end
  endtask

  task automatic test_readback();
    logic [7:0] d;
    wr(16'hFF01, 8'hA5);
    wr(16'hFF02, 8'h81);
    rd(16'hFF02, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL rb_sc_busy: got %h want ff", d);
    end
    rd(16'hFF01, d);
    checks++;
    if (d !== 8'hA5) begin
      errors++; $display("FAIL rb_sb: got %h want a5", d);
    end
    rd(16'hFF03, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL rb_ff03: got %h want ff", d);
    end
    rd(16'hFF00, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL rb_ff00: got %h want ff", d);
    end
    bus_i.addr = 16'hFF01;
    #1;
    checks++;
    if (bus_i.rdata !== 8'hFF) begin
      errors++; $display("FAIL rb_noread: got %h want ff", bus_i.rdata);
    end
    wr(16'hFF03, 8'h00);
    wr(16'hFF00, 8'h00);
    rd(16'hFF02, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++; $display("FAIL rb_outside_wr: got %h want ff", d);
    end
    wr(16'hFF02, 8'h00);
    rd(16'hFF02, d);
    checks++;
    if (d !== 8'h7E) begin
      errors++; $display("FAIL rb_stop: got %h want 7e", d);
    end
  endtask

  task automatic test_internal();
    logic [7:0] orig, e, d;
    logic       sin, esck;
    for (int it = 0; it < 3; it++) begin
      orig = (it == 0) ? 8'h48 : 8'($urandom);
      sin  = (it == 0) ? 1'b1 : 1'($urandom);
      serial_in = sin;
      wr(16'hFF01, orig);
      wr(16'hFF02, 8'h81);
      for (int j = 0; j <= 8*N + 1; j++) begin
        e = shifted(orig, sin, j / N);
        esck = (j < 8*N) ? ((j % N) >= N/2) : 1'b1;
        checks++;
        if (serial_out !== e[7]) begin
          errors++; $display("FAIL int_sout j=%0d: got %b want %b", j, serial_out, e[7]);
        end
        checks++;
        if (serial_clk_out !== esck) begin
          errors++; $display("FAIL int_sck j=%0d: got %b want %b", j, serial_clk_out, esck);
        end
        checks++;
        if (serial_irq !== (j == 8*N)) begin
          errors++; $display("FAIL int_irq j=%0d: got %b want %b", j, serial_irq, j == 8*N);
        end
        checks++;
        if (tx_valid !== (j == 0)) begin
          errors++; $display("FAIL int_txv j=%0d: got %b want %b", j, tx_valid, j == 0);
        end
        if (j == 0) begin
          checks++;
          if (tx_byte !== orig) begin
            errors++; $display("FAIL int_txbyte: got %h want %h", tx_byte, orig);
          end
        end
        if (j < 8*N + 1) cyc();
      end
      rd(16'hFF01, d);
      checks++;
      if (d !== {8{sin}}) begin
        errors++; $display("FAIL int_sb_end: got %h want %h", d, {8{sin}});
      end
      rd(16'hFF02, d);
      checks++;
      if (d !== 8'h7F) begin
        errors++; $display("FAIL int_sc_end: got %h want 7f", d);
      end
    end
  endtask

  task automatic test_external();
    logic [7:0] orig, d, e;
    logic       sin;
    for (int it = 0; it < 2; it++) begin
      orig = (it == 0) ? 8'h0F : 8'($urandom);
      sin  = (it == 0) ? 1'b0 : 1'($urandom);
      serial_in = sin;
      ext_clk = 1'b0;
      wr(16'hFF01, orig);
      wr(16'hFF02, 8'h80);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        ext_clk = 1'b1;
        cyc();
        e = shifted(orig, sin, k);
        rd(16'hFF01, d);
        checks++;
        if (d !== e) begin
          errors++; $display("FAIL ext_sb edge=%0d: got %h want %h", k, d, e);
        end
        checks++;
        if (serial_irq !== (k == 8)) begin
          errors++; $display("FAIL ext_irq edge=%0d: got %b want %b", k, serial_irq, k == 8);
        end
        checks++;
        if (serial_clk_out !== 1'b1) begin
          errors++; $display("FAIL ext_sck edge=%0d: got %b want 1", k, serial_clk_out);
        end
        repeat (3) begin
          cyc();
          rd(16'hFF01, d);
          checks++;
          if (d !== e || serial_irq !== 1'b0) begin
            errors++; $display("FAIL ext_hold edge=%0d: sb %h irq %b want %h 0", k, d, serial_irq, e);
          end
        end
        @(negedge clk);
        ext_clk = 1'b0;
        cyc();
      end
      rd(16'hFF02, d);
      checks++;
      if (d !== 8'h7E) begin
        errors++; $display("FAIL ext_sc_end: got %h want 7e", d);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] orig, d, e;
    logic       sin;
    orig = 8'($urandom);
    sin  = 1'($urandom);
    serial_in = sin;
    wr(16'hFF01, orig);
    wr(16'hFF02, 8'h81);
    repeat (3*N + 2) cyc();
    wr(16'hFF02, 8'h01);
    e = shifted(orig, sin, 3);
    rd(16'hFF01, d);
    checks++;
    if (d !== e) begin
      errors++; $display("FAIL abort_sb: got %h want %h", d, e);
    end
    rd(16'hFF02, d);
    checks++;
    if (d !== 8'h7F) begin
      errors++; $display("FAIL abort_sc: got %h want 7f", d);
    end
    for (int j = 0; j < 10*N; j++) begin
      cyc();
      checks++;
      if (serial_irq !== 1'b0) begin
        errors++; $display("FAIL abort_irq j=%0d: got 1 want 0", j);
      end
    end
    rd(16'hFF01, d);
    checks++;
    if (d !== e) begin
      errors++; $display("FAIL abort_sb_hold: got %h want %h", d, e);
    end
  endtask

  task automatic test_collision();
    logic [7:0] orig, d, tx2, x;
    logic       sin;
    orig = 8'($urandom);
    sin  = 1'($urandom);
    serial_in = sin;
    wr(16'hFF01, orig);
    wr(16'hFF02, 8'h81);
    repeat (8*N - 1) cyc();
    wr(16'hFF02, 8'h00);
    checks++;
    if (serial_irq !== 1'b0) begin
      errors++; $display("FAIL col_irq: got 1 want 0");
    end
    rd(16'hFF02, d);
    checks++;
    if (d !== 8'h7E) begin
      errors++; $display("FAIL col_sc: got %h want 7e", d);
    end
    for (int j = 0; j < 2*N; j++) begin
      cyc();
      checks++;
      if (serial_irq !== 1'b0) begin
        errors++; $display("FAIL col_irq_after j=%0d: got 1 want 0", j);
      end
    end
    orig = 8'($urandom);
    wr(16'hFF01, orig);
    wr(16'hFF02, 8'h81);
    repeat (5*N + 3) cyc();
    tx2 = shifted(orig, sin, 5);
    wr(16'hFF02, 8'h81);
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== tx2) begin
      errors++; $display("FAIL restart_tx: txv %b byte %h want 1 %h", tx_valid, tx_byte, tx2);
    end
    for (int j = 1; j <= 8*N; j++) begin
      cyc();
      checks++;
      if (serial_irq !== (j == 8*N)) begin
        errors++; $display("FAIL restart_irq j=%0d: got %b want %b", j, serial_irq, j == 8*N);
      end
    end
    rd(16'hFF01, d);
    checks++;
    if (d !== {8{sin}}) begin
      errors++; $display("FAIL restart_sb: got %h want %h", d, {8{sin}});
    end
    wr(16'hFF02, 8'h81);
    repeat (N - 1) cyc();
    x = 8'($urandom);
    wr(16'hFF01, x);
    rd(16'hFF01, d);
    checks++;
    if (d !== x) begin
      errors++; $display("FAIL sbwr_shift: got %h want %h", d, x);
    end
    wr(16'hFF02, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] orig, d;
    orig = 8'($urandom) | 8'h08;
    serial_in = 1'($urandom);
    wr(16'hFF01, orig);
    wr(16'hFF02, 8'h81);
    repeat (4*N + 2) cyc();
    checks++;
    if (serial_out !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre_sout: got %b want 1", serial_out);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc();
    checks++;
    if (serial_out !== 1'b0 || serial_clk_out !== 1'b1) begin
      errors++; $display("FAIL rstmid_link: sout %b sck %b want 0 1", serial_out, serial_clk_out);
    end
    checks++;
    if (serial_irq !== 1'b0 || tx_valid !== 1'b0 || tx_byte !== 8'h00) begin
      errors++; $display("FAIL rstmid_out: irq %b txv %b byte %h want 0 0 00", serial_irq, tx_valid, tx_byte);
    end
    rd(16'hFF02, d);
    checks++;
    if (d !== 8'h7E) begin
      errors++; $display("FAIL rstmid_sc: got %h want 7e", d);
    end
    reset = 1'b0;
    for (int j = 0; j < 10*N; j++) begin
      cyc();
      checks++;
      if (serial_irq !== 1'b0 || tx_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_after j=%0d: irq %b txv %b want 0 0", j, serial_irq, tx_valid);
      end
    end
    rd(16'hFF01, d);
    checks++;
    if (d !== 8'h00) begin
      errors++; $display("FAIL rstmid_sb: got %h want 00", d);
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_internal();
    test_external();
    test_abort();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
